uart_link_ctrl: RTL and testbench
=================================

Name: uart_link_ctrl

Overview:
Sequencing controller for the UART FIFO ports. It drains the RX FIFO, latches the last received byte, and echoes RX bytes once the game has ended. It also sends a fixed game-over message, read byte-by-byte from an external combinational ROM, on the rising edge of game_over. It sits between the uart instance (rd_uart/wr_uart/r_data/w_data/rx_empty/tx_full) and game logic, and arbitrates the single TX write port between the message sender and the echo path.

Parameters:
MSG_LEN, 11, number of message bytes sent per game_over edge (1..2^AW)
AW, 4, width of msg_addr

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
game_over  input  1  level from game logic
rx_empty  input  1  UART RX FIFO empty; r_data valid while 0 (first-word fall-through)
r_data  input  8  RX FIFO head byte
rd_uart  output  1  RX FIFO pop strobe
tx_full  input  1  UART TX FIFO full
wr_uart  output  1  TX FIFO push strobe
w_data  output  8  TX FIFO push byte
msg_addr  output  AW  message ROM address
msg_data  input  8  message ROM data, combinational from msg_addr
echo_en  output  1  echo mode active (sticky)
last_char  output  8  last byte popped from RX FIFO
busy  output  1  TX FSM not IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, echo_en=0, go_prev=0, msg_pend=0, echo_pend=0, echo_buf=0, msg_addr=0, last_char=0. Comb outputs rd_uart=0, wr_uart=0, w_data=0, busy=0.
- echo_en: set at any edge with game_over=1; cleared only by reset.
- Edge detect: go_prev<=game_over each cycle. game_over & ~go_prev sets msg_pend. An edge while msg_pend=1 or state=MSG is ignored (no queueing). Because go_prev resets to 0, game_over held high through reset triggers one message after reset.
- RX path (comb): rd_uart = ~rx_empty & ~(echo_en & echo_pend).
  - On a pop edge: last_char<=r_data.
  - If echo_en was 1 before that edge: echo_buf<=r_data and echo_pend<=1.
  - A byte popped on the same edge that sets echo_en is not echoed.
  - With echo_en=0, RX is drained every cycle and bytes are discarded except last_char.
- TX FSM states: IDLE, MSG, ECHO.
  - IDLE: msg_pend -> MSG (clear msg_pend, msg_addr<=0). Else echo_pend -> ECHO. Message wins when both are pending.
  - MSG: wr_uart = ~tx_full, w_data = msg_data.
    - On each write: msg_addr++.
    - A write with msg_addr==MSG_LEN-1 -> IDLE, msg_addr<=0.
    - tx_full stalls without skipping. The message is atomic and echo waits.
  - ECHO: wr_uart = ~tx_full, w_data = echo_buf. On write: echo_pend<=0 -> IDLE.
  - wr_uart is never asserted when tx_full=1. At most one write per cycle.
  - w_data=0 whenever wr_uart=0.
- Latency:
  - game_over sampled high at edge E0 -> MSG entered at E1 -> first wr_uart in the cycle after E1 (tx_full=0).
  - Echo: pop at edge P0 -> ECHO at P1 -> wr_uart in the cycle after P1.
  - Steady-state echo throughput is one byte per 3 cycles.
- busy = (state != IDLE).
- Reset mid-message aborts it. No resume. msg_addr returns to 0.

Test Plan:
1. Reset: hold rst=0 with random inputs -> all outputs 0, msg_addr=0. Release with game_over=0, rx_empty=1 -> no wr_uart/rd_uart for 20 cycles.
2. Message send: game_over 0->1, tx_full=0, ROM = "GAME OVER\r\n" -> 11 consecutive wr_uart pulses with w_data 0x47,0x41,0x4D,0x45,0x20,0x4F,0x56,0x45,0x52,0x0D,0x0A. The first pulse occurs 2 cycles after the sampling edge. busy falls after the 11th. echo_en=1.
3. Backpressure: during the message, force tx_full=1 for 5 cycles at byte 4 -> no wr_uart while full, msg_addr holds 4, byte 4 is sent once tx_full drops, and exactly 11 bytes total are written.
4. Pre-game RX: game_over=0, push 0x31,0x32 into the RX FIFO -> two rd_uart pulses, last_char=0x32, zero wr_uart.
5. Echo vs message collision: echo_en=1, RX byte 0x41 popped on the same edge as a new game_over rising edge after reset -> message sent first in full, then a single wr_uart with 0x41. No second RX pop occurs while echo_pend=1.
6. Reset mid-message: assert rst after byte 5 -> wr_uart drops immediately, msg_addr=0. Release with game_over still high -> full 11-byte message restarts from byte 0.

Source files
------------

// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: sits between the UART FIFO ports and the game logic.
// Drains the RX FIFO (keeping the last byte), sends a fixed game-over
// message read from an external combinational ROM on each rising edge of
// game_over, and echoes received bytes once the game has ended. The single
// TX push port is shared between the message sender and the echo path.
module uart_link_ctrl #(
    parameter int MSG_LEN = 11,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          game_over,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    input  logic          tx_full,
    output logic          wr_uart,
    output logic [7:0]    w_data,
    output logic [AW-1:0] msg_addr,
    input  logic [7:0]    msg_data,
    output logic          echo_en,
    output logic [7:0]    last_char,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MSG  = 2'd1;
    localparam logic [1:0] ST_ECHO = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LEN - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    logic [1:0]    state_q,     state_d;
    logic          echo_en_q,   echo_en_d;
    logic          go_prev_q,   go_prev_d;
    logic          msg_pend_q,  msg_pend_d;
    logic          echo_pend_q, echo_pend_d;
    logic [7:0]    echo_buf_q,  echo_buf_d;
    logic [AW-1:0] msg_addr_q,  msg_addr_d;
    logic [7:0]    last_char_q, last_char_d;
    logic          rise_s;

    assign rise_s    = game_over & ~go_prev_q;
    assign msg_addr  = msg_addr_q;
    assign echo_en   = echo_en_q;
    assign last_char = last_char_q;
    assign busy      = (state_q != ST_IDLE);

    // FIFO strobes and TX data; the RX pop is held off while an echo byte
    // is still waiting, and held low during reset.
    always_comb begin
        rd_uart = rst & ~rx_empty & ~(echo_en_q & echo_pend_q);
        wr_uart = 1'b0;
        w_data  = 8'h00;
        case (state_q)
            ST_MSG: begin
                wr_uart = ~tx_full;
                w_data  = tx_full ? 8'h00 : msg_data;
            end
            ST_ECHO: begin
                wr_uart = ~tx_full;
                w_data  = tx_full ? 8'h00 : echo_buf_q;
            end
            default: begin
                wr_uart = 1'b0;
                w_data  = 8'h00;
            end
        endcase
    end

    // Next-state logic: edge detect, RX capture and the TX arbitration FSM.
    always_comb begin
        state_d     = state_q;
        msg_pend_d  = msg_pend_q;
        echo_pend_d = echo_pend_q;
        echo_buf_d  = echo_buf_q;
        msg_addr_d  = msg_addr_q;
        last_char_d = last_char_q;
        echo_en_d   = echo_en_q | game_over;
        go_prev_d   = game_over;

        // A byte popped on the edge that first sets echo_en is not echoed,
        // so the echo decision looks at the registered echo_en only.
        if (rd_uart) begin
            last_char_d = r_data;
            if (echo_en_q) begin
                echo_buf_d  = r_data;
                echo_pend_d = 1'b1;
            end else begin
                echo_buf_d  = echo_buf_q;
            end
        end else begin
            last_char_d = last_char_q;
        end

        // Edges arriving while a message is pending or in flight are dropped.
        if (rise_s && !msg_pend_q && (state_q != ST_MSG)) begin
            msg_pend_d = 1'b1;
        end else begin
            msg_pend_d = msg_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (msg_pend_q) begin
                    state_d    = ST_MSG;
                    msg_pend_d = 1'b0;
                    msg_addr_d = '0;
                end else if (echo_pend_q) begin
                    state_d = ST_ECHO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MSG: begin
                if (wr_uart) begin
                    if (msg_addr_q == LAST_ADDR) begin
                        state_d    = ST_IDLE;
                        msg_addr_d = '0;
                    end else begin
                        msg_addr_d = msg_addr_q + ADDR_ONE;
                    end
                end else begin
                    msg_addr_d = msg_addr_q;
                end
            end
            ST_ECHO: begin
                if (wr_uart) begin
                    echo_pend_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ECHO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any message in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            echo_en_q   <= 1'b0;
            go_prev_q   <= 1'b0;
            msg_pend_q  <= 1'b0;
            echo_pend_q <= 1'b0;
            echo_buf_q  <= 8'h00;
            msg_addr_q  <= '0;
            last_char_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            echo_en_q   <= echo_en_d;
            go_prev_q   <= go_prev_d;
            msg_pend_q  <= msg_pend_d;
            echo_pend_q <= echo_pend_d;
            echo_buf_q  <= echo_buf_d;
            msg_addr_q  <= msg_addr_d;
            last_char_q <= last_char_d;
        end
    end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: emulates the RX FIFO with a queue, a message ROM,
// and checks every TX push against a queue of expected bytes.
module tb_uart_link_ctrl;

    localparam int MSG_LEN = 11;
    localparam int AW      = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          game_over = 1'b0;
    logic          rx_empty = 1'b1;
    logic [7:0]    r_data = 8'h00;
    logic          rd_uart;
    logic          tx_full = 1'b0;
    logic          wr_uart;
    logic [7:0]    w_data;
    logic [AW-1:0] msg_addr;
    logic [7:0]    msg_data;
    logic          echo_en;
    logic [7:0]    last_char;
    logic          busy;

    logic [7:0] rom [0:15];
    logic [7:0] exp_msg [0:10];

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    bit         echo_en_m;
    logic [7:0] last_pop_m;
    int         n_tests;
    int         n_fail;
    bit         s_wr;
    bit         s_rd;
    logic [7:0] s_wd;
    int         wr_cnt;
    int         rd_cnt;

    uart_link_ctrl #(.MSG_LEN(MSG_LEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .game_over (game_over),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .msg_addr  (msg_addr),
        .msg_data  (msg_data),
        .echo_en   (echo_en),
        .last_char (last_char),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign msg_data = rom[msg_addr];

    task automatic drive_rx();
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic load_msg();
        for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(exp_msg[i]);
    endtask

    // One clock: sample outputs before the edge, then update the models.
    task automatic step();
        logic [7:0] popped;
        logic [7:0] e;
        logic       go_s;
        #1;
        s_wr   = wr_uart;
        s_rd   = rd_uart;
        s_wd   = w_data;
        popped = r_data;
        go_s   = game_over;
        n_tests++;
        if (s_wr && tx_full) begin
            n_fail++;
            $display("FAIL wr_while_full: wr_uart=%0b tx_full=%0b", s_wr, tx_full);
        end
        n_tests++;
        if (!s_wr && s_wd !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_wdata: w_data=%02h expected 00", s_wd);
        end
        if (s_wr) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: w_data=%02h expected no write", s_wd);
            end else begin
                e = exp_q.pop_front();
                if (s_wd !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: w_data=%02h expected %02h", s_wd, e);
                end
            end
            wr_cnt++;
        end
        if (s_rd) begin
            rd_cnt++;
            n_tests++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_empty: rd_uart=1 expected 0 with rx empty");
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (s_rd && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            last_pop_m = popped;
            if (echo_en_m) exp_q.push_back(popped);
        end
        if (go_s) echo_en_m = 1'b1;
        drive_rx();
    endtask

    task automatic run_writes(input int target, input int bound, input string name);
        int n;
        n = 0;
        while (wr_cnt < target && n < bound) begin
            step();
            n++;
        end
        n_tests++;
        if (wr_cnt < target) begin
            n_fail++;
            $display("FAIL %s_timeout: writes=%0d expected %0d", name, wr_cnt, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        game_over = 1'b0;
        tx_full = 1'b0;
        @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        echo_en_m = 1'b0;
        drive_rx();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            game_over = 1'($urandom);
            rx_empty  = 1'($urandom);
            r_data    = 8'($urandom);
            tx_full   = 1'($urandom);
            #1;
            n_tests++;
            if ({rd_uart, wr_uart, w_data, busy, echo_en, last_char, msg_addr} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: rd=%0b wr=%0b wd=%02h busy=%0b echo=%0b last=%02h addr=%0h expected all 0",
                         rd_uart, wr_uart, w_data, busy, echo_en, last_char, msg_addr);
            end
        end
        @(negedge clk);
        game_over = 1'b0;
        tx_full = 1'b0;
        rx_q.delete();
        exp_q.delete();
        echo_en_m = 1'b0;
        drive_rx();
        rst = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
        repeat (20) step();
        n_tests++;
        if (wr_cnt != 0 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: writes=%0d pops=%0d expected 0 0", wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_message();
        int first;
        int last;
        first = -1;
        last = -1;
        wr_cnt = 0;
        load_msg();
        game_over = 1'b1;
        tx_full = 1'b0;
        for (int i = 0; i < 40 && wr_cnt < MSG_LEN; i++) begin
            step();
            if (s_wr && first < 0) first = i;
            if (s_wr) last = i;
            if (i == 1) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL msg_busy: busy=%0b expected 1", busy);
                end
            end
        end
        n_tests++;
        if (first != 2) begin
            n_fail++;
            $display("FAIL msg_latency: first write at %0d expected 2", first);
        end
        n_tests++;
        if (wr_cnt != MSG_LEN || last - first != MSG_LEN - 1) begin
            n_fail++;
            $display("FAIL msg_burst: writes=%0d span=%0d expected 11 10", wr_cnt, last - first);
        end
        n_tests++;
        if (busy !== 1'b0 || echo_en !== 1'b1 || msg_addr !== '0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL msg_end: busy=%0b echo_en=%0b addr=%0h left=%0d expected 0 1 0 0",
                     busy, echo_en, msg_addr, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        game_over = 1'b0;
        step();
        step();
        load_msg();
        game_over = 1'b1;
        wr_cnt = 0;
        run_writes(4, 30, "bp_head");
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (s_wr || msg_addr !== 4'd4) begin
                n_fail++;
                $display("FAIL bp_stall: wr=%0b addr=%0h expected 0 4", s_wr, msg_addr);
            end
        end
        tx_full = 1'b0;
        step();
        n_tests++;
        if (!s_wr || s_wd !== 8'h20) begin
            n_fail++;
            $display("FAIL bp_resume: wr=%0b w_data=%02h expected 1 20", s_wr, s_wd);
        end
        run_writes(MSG_LEN, 30, "bp_tail");
        repeat (5) step();
        n_tests++;
        if (wr_cnt != MSG_LEN || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_total: writes=%0d left=%0d expected 11 0", wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_pre_game_rx();
        do_reset();
        rx_q.push_back(8'h31);
        rx_q.push_back(8'h32);
        drive_rx();
        wr_cnt = 0;
        rd_cnt = 0;
        repeat (6) step();
        n_tests++;
        if (rd_cnt != 2 || last_char !== 8'h32 || wr_cnt != 0 || echo_en !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_game_rx: pops=%0d last=%02h writes=%0d echo_en=%0b expected 2 32 0 0",
                     rd_cnt, last_char, wr_cnt, echo_en);
        end
    endtask

    task automatic test_collision();
        int rd_during;
        int n;
        load_msg();
        game_over = 1'b1;
        wr_cnt = 0;
        run_writes(MSG_LEN, 40, "col_first");
        game_over = 1'b0;
        step();
        rx_q.push_back(8'h41);
        rx_q.push_back(8'h42);
        drive_rx();
        load_msg();
        game_over = 1'b1;
        wr_cnt = 0;
        step();
        n_tests++;
        if (!s_rd) begin
            n_fail++;
            $display("FAIL col_pop: rd_uart=%0b expected 1", s_rd);
        end
        rd_during = 0;
        n = 0;
        while (wr_cnt < MSG_LEN + 1 && n < 60) begin
            step();
            if (s_rd) rd_during++;
            n++;
        end
        n_tests++;
        if (wr_cnt != MSG_LEN + 1 || rd_during != 0) begin
            n_fail++;
            $display("FAIL col_order: writes=%0d pops=%0d expected 12 0", wr_cnt, rd_during);
        end
        n = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0) && n < 20) begin
            step();
            n++;
        end
        n_tests++;
        if (wr_cnt != MSG_LEN + 2 || last_char !== 8'h42 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL col_tail: writes=%0d last=%02h left=%0d expected 13 42 0",
                     wr_cnt, last_char, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int first;
        game_over = 1'b0;
        step();
        load_msg();
        game_over = 1'b1;
        wr_cnt = 0;
        run_writes(5, 30, "mid_head");
        rst = 1'b0;
        #1;
        n_tests++;
        if (wr_uart !== 1'b0 || msg_addr !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abort: wr=%0b addr=%0h busy=%0b expected 0 0 0", wr_uart, msg_addr, busy);
        end
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rx_q.delete();
        echo_en_m = 1'b0;
        drive_rx();
        rst = 1'b1;
        load_msg();
        wr_cnt = 0;
        first = -1;
        for (int i = 0; i < 40 && wr_cnt < MSG_LEN; i++) begin
            step();
            if (s_wr && first < 0) first = i;
        end
        repeat (4) step();
        n_tests++;
        if (first != 2 || wr_cnt != MSG_LEN || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_restart: first=%0d writes=%0d left=%0d expected 2 11 0",
                     first, wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_echo_throughput();
        int idx [3];
        wr_cnt = 0;
        rx_q.push_back(8'hA0);
        rx_q.push_back(8'hA1);
        rx_q.push_back(8'hA2);
        drive_rx();
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_wr && wr_cnt <= 3) idx[wr_cnt-1] = i;
        end
        n_tests++;
        if (wr_cnt != 3 || idx[0] != 2 || idx[1] - idx[0] != 3 || idx[2] - idx[1] != 3) begin
            n_fail++;
            $display("FAIL echo_rate: writes=%0d at %0d,%0d,%0d expected 3 at 2,5,8",
                     wr_cnt, idx[0], idx[1], idx[2]);
        end
    endtask

    task automatic test_random_echo();
        int n;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) rx_q.push_back(8'($urandom));
            drive_rx();
            tx_full = ($urandom_range(0, 2) == 0);
            step();
        end
        tx_full = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0 || rx_q.size() != 0 || last_char !== last_pop_m) begin
            n_fail++;
            $display("FAIL random_echo: left=%0d rx=%0d last=%02h expected 0 0 %02h",
                     exp_q.size(), rx_q.size(), last_char, last_pop_m);
        end
    endtask

    initial begin
        string s;
        s = "GAME OVER\r\n";
        for (int i = 0; i < 16; i++) rom[i] = (i < MSG_LEN) ? s[i] : 8'hFF;
        exp_msg = '{8'h47, 8'h41, 8'h4D, 8'h45, 8'h20, 8'h4F, 8'h56, 8'h45, 8'h52, 8'h0D, 8'h0A};
        n_tests = 0;
        n_fail = 0;
        wr_cnt = 0;
        rd_cnt = 0;
        echo_en_m = 1'b0;
        last_pop_m = 8'h00;
        test_reset();
        test_message();
        test_backpressure();
        test_pre_game_rx();
        test_collision();
        test_reset_mid();
        test_echo_throughput();
        test_random_echo();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
